// File: rtl/player_motion_pkg.sv
// Shared encodings and helpers for the player motion controller.
package player_motion_pkg;

  // Sprite state seen by the renderer.
  typedef enum logic [1:0] {
    PS_STATIC = 2'd0,
    PS_RIGHT  = 2'd1,
    PS_LEFT   = 2'd2,
    PS_UP     = 2'd3
  } pstate_e;

  // Vertical motion state of one character.
  typedef enum logic [1:0] {
    VS_GROUND = 2'd0,
    VS_RISE   = 2'd1,
    VS_FALL   = 2'd2
  } vstate_e;

  // Bits needed to hold a rise counter loaded with jump_ticks.
  function automatic int cnt_width(input int jump_ticks);
    return (jump_ticks < 1) ? 1 : $clog2(jump_ticks + 1);
  endfunction

endpackage

// File: rtl/player_axis_fsm.sv
// One character: horizontal motion, jump/fall state machine, rise counter,
// jump re-arm flag and sprite state. All outputs are registered.
// Optional macro DOUBLE_JUMP_EN allows one extra jump per airtime.
module player_axis_fsm
  import player_motion_pkg::*;
#(
  parameter int POS_W      = 10,
  parameter int X_MAX      = 624,
  parameter int Y_MAX      = 464,
  parameter int STEP_X     = 2,
  parameter int STEP_Y     = 3,
  parameter int JUMP_TICKS = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             level_load,
  input  logic [POS_W-1:0] spawn_x,
  input  logic [POS_W-1:0] spawn_y,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             key_jump,
  input  logic             blocked_left,
  input  logic             blocked_right,
  input  logic             on_ground,
  input  logic             hit_ceiling,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic [1:0]       pstate,
  output logic             airborne
);

  localparam int                CW      = cnt_width(JUMP_TICKS);
  localparam int                WW      = POS_W + 1;
  localparam logic [WW-1:0]     SX      = WW'(STEP_X);
  localparam logic [WW-1:0]     SY      = WW'(STEP_Y);
  localparam logic [WW-1:0]     XM      = WW'(X_MAX);
  localparam logic [WW-1:0]     YM      = WW'(Y_MAX);
  localparam logic [CW-1:0]     JT      = CW'(JUMP_TICKS);

  vstate_e          vs, vs_nxt;
  logic [CW-1:0]    cnt, cnt_nxt, cnt_dec;
  logic             armed, armed_nxt;
  logic [POS_W-1:0] x_nxt, y_nxt;
  pstate_e          ps_nxt;
  logic [WW-1:0]    x_sub, x_add, y_sub, y_add;
  logic [POS_W-1:0] y_up;
  logic             go_left, go_right;
`ifdef DOUBLE_JUMP_EN
  logic             air_used, air_used_nxt;
`endif

  assign go_left  = key_left & ~key_right;
  assign go_right = key_right & ~key_left;

  // Next-state computation for one tick; the register stage decides whether it is taken.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    x_nxt     = pos_x;
    y_nxt     = pos_y;
    vs_nxt    = vs;
    cnt_nxt   = cnt;
    armed_nxt = armed;
`ifdef DOUBLE_JUMP_EN
    air_used_nxt = air_used;
`endif

    // Widened arithmetic: a borrow shows up in the top bit, a carry never wraps.
    x_sub   = {1'b0, pos_x} - SX;
    x_add   = {1'b0, pos_x} + SX;
    y_sub   = {1'b0, pos_y} - SY;
    y_add   = {1'b0, pos_y} + SY;
    y_up    = y_sub[POS_W] ? '0 : y_sub[POS_W-1:0];
    cnt_dec = cnt - CW'(1);

    if (go_left && !blocked_left)
      x_nxt = x_sub[POS_W] ? '0 : x_sub[POS_W-1:0];
    else if (go_right && !blocked_right)
      x_nxt = (x_add > XM) ? XM[POS_W-1:0] : x_add[POS_W-1:0];

    if (!key_jump) armed_nxt = 1'b1;

    unique case (vs)
      VS_GROUND: begin
        if (key_jump && on_ground && armed) begin
          vs_nxt    = VS_RISE;
          cnt_nxt   = JT;
          armed_nxt = 1'b0;
        end else if (!on_ground) begin
          vs_nxt = VS_FALL;
        end
      end
      VS_RISE: begin
        y_nxt   = y_up;
        cnt_nxt = cnt_dec;
        // Rise ends on the tick the counter reaches 1, at a ceiling, or at the top row.
        if (cnt_dec == CW'(1) || cnt_dec == '0 || hit_ceiling || y_up == '0)
          vs_nxt = VS_FALL;
      end
      VS_FALL: begin
        if (on_ground) vs_nxt = VS_GROUND;
        else           y_nxt  = (y_add > YM) ? YM[POS_W-1:0] : y_add[POS_W-1:0];
      end
      default: vs_nxt = VS_GROUND;
    endcase

`ifdef DOUBLE_JUMP_EN
    // A fresh press while airborne restarts the rise once per airtime.
    if (vs != VS_GROUND && key_jump && armed && !air_used) begin
      vs_nxt       = VS_RISE;
      cnt_nxt      = JT;
      armed_nxt    = 1'b0;
      air_used_nxt = 1'b1;
      y_nxt        = pos_y;
    end
    if (vs_nxt == VS_GROUND) air_used_nxt = 1'b0;
`endif

    if (vs_nxt != VS_GROUND) ps_nxt = PS_UP;
    else if (go_right)       ps_nxt = PS_RIGHT;
    else if (go_left)        ps_nxt = PS_LEFT;
    else                     ps_nxt = PS_STATIC;
  end

  // State and output registers: level_load beats tick, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      pos_x    <= '0;
      pos_y    <= '0;
      pstate   <= PS_STATIC;
      airborne <= 1'b0;
      vs       <= VS_GROUND;
      cnt      <= '0;
      armed    <= 1'b1;
`ifdef DOUBLE_JUMP_EN
      air_used <= 1'b0;
`endif
    end else if (level_load) begin
      pos_x    <= spawn_x;
      pos_y    <= spawn_y;
      pstate   <= PS_STATIC;
      airborne <= 1'b0;
      vs       <= VS_GROUND;
      cnt      <= '0;
      armed    <= 1'b1;
`ifdef DOUBLE_JUMP_EN
      air_used <= 1'b0;
`endif
    end else if (tick) begin
      pos_x    <= x_nxt;
      pos_y    <= y_nxt;
      pstate   <= ps_nxt;
      airborne <= (vs_nxt != VS_GROUND);
      vs       <= vs_nxt;
      cnt      <= cnt_nxt;
      armed    <= armed_nxt;
`ifdef DOUBLE_JUMP_EN
      air_used <= air_used_nxt;
`endif
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Motion controller for NUM_PLAYERS independent characters; one
// player_axis_fsm per player, packed buses sliced per player.
// Optional macro DOUBLE_JUMP_EN enables a single air jump per airtime.
module player_motion_ctrl
  import player_motion_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int POS_W       = 10,
  parameter int X_MAX       = 624,
  parameter int Y_MAX       = 464,
  parameter int STEP_X      = 2,
  parameter int STEP_Y      = 3,
  parameter int JUMP_TICKS  = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         level_load,
  input  logic [NUM_PLAYERS*POS_W-1:0] spawn_x,
  input  logic [NUM_PLAYERS*POS_W-1:0] spawn_y,
  input  logic [NUM_PLAYERS-1:0]       key_left,
  input  logic [NUM_PLAYERS-1:0]       key_right,
  input  logic [NUM_PLAYERS-1:0]       key_jump,
  input  logic [NUM_PLAYERS-1:0]       blocked_left,
  input  logic [NUM_PLAYERS-1:0]       blocked_right,
  input  logic [NUM_PLAYERS-1:0]       on_ground,
  input  logic [NUM_PLAYERS-1:0]       hit_ceiling,
  output logic [NUM_PLAYERS*POS_W-1:0] pos_x,
  output logic [NUM_PLAYERS*POS_W-1:0] pos_y,
  output logic [NUM_PLAYERS*2-1:0]     pstate,
  output logic [NUM_PLAYERS-1:0]       airborne
);

  // One identical, independent motion unit per player.
  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
    player_axis_fsm #(
      .POS_W      (POS_W),
      .X_MAX      (X_MAX),
      .Y_MAX      (Y_MAX),
      .STEP_X     (STEP_X),
      .STEP_Y     (STEP_Y),
      .JUMP_TICKS (JUMP_TICKS)
    ) u_player (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick),
      .level_load    (level_load),
      .spawn_x       (spawn_x[i*POS_W +: POS_W]),
      .spawn_y       (spawn_y[i*POS_W +: POS_W]),
      .key_left      (key_left[i]),
      .key_right     (key_right[i]),
      .key_jump      (key_jump[i]),
      .blocked_left  (blocked_left[i]),
      .blocked_right (blocked_right[i]),
      .on_ground     (on_ground[i]),
      .hit_ceiling   (hit_ceiling[i]),
      .pos_x         (pos_x[i*POS_W +: POS_W]),
      .pos_y         (pos_y[i*POS_W +: POS_W]),
      .pstate        (pstate[i*2 +: 2]),
      .airborne      (airborne[i])
    );
  end

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Parametrised successor to the fixed two-player jump/move logic in the game top level.
- Per-player horizontal motion, jump/fall state machine and sprite-state output for NUM_PLAYERS characters.
- Driven by keyboard key_down bits, a motion tick and per-player collision flags from the map logic.
- Outputs registered pixel positions to the VGA renderer; reloads spawn points on level change.

Parameters:
- NUM_PLAYERS, 2: number of independent characters.
- POS_W, 10: width of each x/y coordinate.
- X_MAX, 624: largest legal x (sprite left edge).
- Y_MAX, 464: largest legal y (sprite top edge).
- STEP_X, 2: pixels moved per tick horizontally.
- STEP_Y, 3: pixels moved per tick vertically.
- JUMP_TICKS, 20: maximum rise duration in ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- tick  in  1  one-cycle motion strobe (e.g. once per frame).
- level_load  in  1  one-cycle pulse: load spawn positions.
- spawn_x  in  NUM_PLAYERS*POS_W  per-player spawn x.
- spawn_y  in  NUM_PLAYERS*POS_W  per-player spawn y.
- key_left  in  NUM_PLAYERS  left key held, bit i = player i.
- key_right  in  NUM_PLAYERS  right key held.
- key_jump  in  NUM_PLAYERS  jump key held.
- blocked_left  in  NUM_PLAYERS  wall immediately left.
- blocked_right  in  NUM_PLAYERS  wall immediately right.
- on_ground  in  NUM_PLAYERS  floor directly below.
- hit_ceiling  in  NUM_PLAYERS  ceiling directly above.
- pos_x  out  NUM_PLAYERS*POS_W  registered x per player.
- pos_y  out  NUM_PLAYERS*POS_W  registered y per player.
- pstate  out  NUM_PLAYERS*2  sprite state: 0 STATIC, 1 RIGHT, 2 LEFT, 3 UP.
- airborne  out  NUM_PLAYERS  high in RISE or FALL.

Behaviour:
- One clock, clk; reset rst is asynchronous and active-low.
- Reset values: pos_x/pos_y = 0, pstate = STATIC, airborne = 0, FSM = GROUND, rise counter = 0, jump_armed = 1.
- All players are identical and independent. All outputs are registered.
- Outputs change on the clk edge that samples tick = 1 (visible the cycle after the tick cycle).
- Priority per cycle: level_load > tick > hold.
- level_load: pos <= spawn, FSM GROUND, counter 0, jump_armed 1, pstate STATIC, even if tick is simultaneous.
- Horizontal move on tick:
  - left and right both held, or neither held: no move.
  - Left only and not blocked_left: x <= max(x - STEP_X, 0).
  - Right only and not blocked_right: x <= min(x + STEP_X, X_MAX).
  - A blocked direction does not move but still sets pstate.
- Vertical FSM (evaluated on tick):
  - GROUND -> RISE when key_jump & on_ground & jump_armed; counter <= JUMP_TICKS, jump_armed <= 0.
  - GROUND -> FALL when !on_ground (walked off an edge).
  - RISE: y <= max(y - STEP_Y, 0); counter decrements. Go to FALL when counter reaches 1, hit_ceiling = 1, or y = 0.
  - FALL: if on_ground, go to GROUND with y unchanged; else y <= min(y + STEP_Y, Y_MAX).
  - jump_armed <= 1 on any tick where key_jump = 0. Holding jump never auto-rejumps.
- pstate after tick: UP if the next FSM state ≠ GROUND; else RIGHT/LEFT per the resolved key direction; else STATIC.
- airborne = (FSM ≠ GROUND).
- Coordinate arithmetic uses POS_W+1-bit intermediates so saturation never wraps.

Optional Feature:
- Macro DOUBLE_JUMP_EN.
- Defined:
  - One extra jump per airtime: in RISE or FALL with key_jump & jump_armed & !air_jump_used -> RISE, counter <= JUMP_TICKS, air_jump_used <= 1, jump_armed <= 0.
  - air_jump_used clears on entering GROUND, on level_load and on reset.
- Undefined: jump input while airborne is ignored; no air_jump_used register exists.

Decomposition:
- Package player_motion_pkg holds:
  - pstate encodings STATIC/RIGHT/LEFT/UP.
  - Vertical FSM encodings GROUND/RISE/FALL.
  - A counter-width function clog2(JUMP_TICKS+1).
- Sub-module player_axis_fsm implements one player (position, FSM, counter, arm flag). The top instantiates it NUM_PLAYERS times in a generate loop and slices the packed buses.

Test Plan:
- Reset, then level_load with spawn (100,200) for P0 and (300,200) for P1 -> pos matches spawn, pstate 0, airborne 0.
- P0 key_right, 5 ticks, on_ground = 1 -> x = 110, pstate 1. With left and right both held -> x stays, pstate 0.
- x = 1, key_left, 1 tick -> x = 0 (saturates). x = 623, key_right -> x = 624.
- Jump from y = 200, on_ground drops after the first tick, 20 ticks -> y = 143, then FALL adds 3 per tick until on_ground -> GROUND, pstate leaves UP.
- hit_ceiling asserted on rise tick 4 -> FALL next tick, y = 188 minimum.
- Jump held through landing -> no second jump until one tick with key_jump = 0.
- level_load mid-RISE coincident with tick -> spawn position, GROUND.
- With DOUBLE_JUMP_EN: release then press in FALL -> new RISE, a third press is ignored.
